// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample format, frame geometry and frame-load sources.
package i2s_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_BUFFER,
        LOAD_BYPASS,
        LOAD_ZERO
    } load_src_e;

    // Right channel occupies bits 15..30 so the word select leads each MSB by one BCLK.
    function automatic logic lrclk_for_bit(input logic [BIT_CNT_W-1:0] bit_idx);
        return (bit_idx >= BIT_CNT_W'(15)) && (bit_idx <= BIT_CNT_W'(30));
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every DIV clk_12 cycles and flags the 1->0 toggle cycle.
module i2s_bclk_gen #(
    parameter int DIV = 4
) (
    input  logic clk_12,
    input  logic reset,
    output logic bclk,
    output logic bclk_fall
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             div_wrap;

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign bclk_fall = div_wrap && bclk;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_12) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S stereo transmitter: one-entry sample buffer, 32-bit frame serializer, word select.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic    clk_12,
    input  logic    reset,
    input  sample_t sample_left,
    input  sample_t sample_right,
    input  logic    sample_valid,
    output logic    sample_ready,
    output logic    bclk,
    output logic    lrclk,
    output logic    sdata,
    output logic    frame_start,
    output logic    underrun
);

    logic                  bclk_fall;
    logic                  frame_edge;
    logic                  accept;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_next;
    logic                  buf_full;
    sample_t               buf_left;
    sample_t               buf_right;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] load_word;
    load_src_e             load_src;

    i2s_bclk_gen #(.DIV(DIV)) u_bclk_gen (
        .clk_12    (clk_12),
        .reset     (reset),
        .bclk      (bclk),
        .bclk_fall (bclk_fall)
    );

    assign sample_ready = ~buf_full;
    assign accept       = sample_valid && sample_ready;
    assign bit_next     = bit_cnt + 1'b1;
    assign frame_edge   = bclk_fall && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        load_src  = LOAD_NONE;
        load_word = '0;
        if (frame_edge) begin
            if (buf_full) begin
                load_src  = LOAD_BUFFER;
                load_word = {buf_left, buf_right};
            end else if (sample_valid) begin
                load_src  = LOAD_BYPASS;
                load_word = {sample_left, sample_right};
            end else begin
                load_src  = LOAD_ZERO;
            end
        end
    end

    always_ff @(posedge clk_12) begin
        if (reset) begin
            bit_cnt     <= '1;
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            buf_full    <= 1'b0;
            shift_reg   <= '0;
        end else begin
            frame_start <= (load_src != LOAD_NONE);
            underrun    <= (load_src == LOAD_ZERO);

            if (bclk_fall) begin
                bit_cnt <= bit_next;
                lrclk   <= lrclk_for_bit(bit_next);
                if (frame_edge) begin
                    sdata     <= load_word[FRAME_BITS-1];
                    shift_reg <= {load_word[FRAME_BITS-2:0], 1'b0};
                end else begin
                    sdata     <= shift_reg[FRAME_BITS-1];
                    shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                end
            end

            // A pair offered on an empty-buffer boundary goes straight to the serializer.
            if (load_src == LOAD_BUFFER) begin
                buf_full <= 1'b0;
            end else if (accept && (load_src != LOAD_BYPASS)) begin
                buf_full <= 1'b1;
            end
        end
    end

    // NOTE: buffer payload has no reset; buf_full alone qualifies it, so the
    // data registers stay cheap enable-only flops.
    always_ff @(posedge clk_12) begin
        if (!reset && accept && (load_src != LOAD_BYPASS)) begin
            buf_left  <= sample_left;
            buf_right <= sample_right;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx (DIV=4 and DIV=2 builds) against a cycle-count frame model.
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int DIV_A = 4;
    localparam int DIV_B = 2;

    logic    clk_12 = 1'b0;
    logic    reset;
    sample_t sample_left;
    sample_t sample_right;
    logic    sample_valid;
    logic    sel;

    logic ready_a, bclk_a, lrclk_a, sdata_a, fs_a, ur_a;
    logic ready_b, bclk_b, lrclk_b, sdata_b, fs_b, ur_b;
    logic obs_ready, obs_bclk, obs_lrclk, obs_sdata, obs_fs, obs_ur;

    always #5 clk_12 = ~clk_12;

    i2s_tx #(.DIV(DIV_A)) dut_a (
        .clk_12(clk_12), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(ready_a), .bclk(bclk_a), .lrclk(lrclk_a),
        .sdata(sdata_a), .frame_start(fs_a), .underrun(ur_a)
    );

    i2s_tx #(.DIV(DIV_B)) dut_b (
        .clk_12(clk_12), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(ready_b), .bclk(bclk_b), .lrclk(lrclk_b),
        .sdata(sdata_b), .frame_start(fs_b), .underrun(ur_b)
    );

    always_comb begin
        obs_ready = sel ? ready_b : ready_a;
        obs_bclk  = sel ? bclk_b  : bclk_a;
        obs_lrclk = sel ? lrclk_b : lrclk_a;
        obs_sdata = sel ? sdata_b : sdata_a;
        obs_fs    = sel ? fs_b    : fs_a;
        obs_ur    = sel ? ur_b    : ur_a;
    end

    // Model: n counts non-reset cycles; pending holds accepted pairs not yet framed.
    int          vectors     = 0;
    int          miscompares = 0;
    int          n           = 0;
    int          k_cur       = 31;
    int          div_m       = DIV_A;
    int          frames      = 0;
    int          underruns   = 0;
    logic [31:0] word        = '0;
    logic        last_accept = 1'b0;
    logic [31:0] pending[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d after reset, DIV=%0d)",
                   tag, obs, exp, n, div_m);
        end
    endtask

    function automatic bit is_load(input int m);
        int f;
        f = m / (2 * div_m);
        return (m > 0) && (m % (2 * div_m) == 0) && ((f + 31) % 32 == 0);
    endfunction

    task automatic step();
        logic was_reset;
        logic load;
        logic exp_ur;
        int   f;
        was_reset   = reset;
        last_accept = !reset && sample_valid && obs_ready;
        if (last_accept) pending.push_back({sample_left, sample_right});
        @(negedge clk_12);
        if (was_reset) begin
            n = 0;
            k_cur = 31;
            word = '0;
            pending.delete();
            check("rst_bclk",  {31'd0, obs_bclk},  32'd0);
            check("rst_lrclk", {31'd0, obs_lrclk}, 32'd0);
            check("rst_sdata", {31'd0, obs_sdata}, 32'd0);
            check("rst_fs",    {31'd0, obs_fs},    32'd0);
            check("rst_ur",    {31'd0, obs_ur},    32'd0);
            check("rst_ready", {31'd0, obs_ready}, 32'd1);
        end else begin
            n++;
            f      = n / (2 * div_m);
            k_cur  = (31 + f) % 32;
            load   = is_load(n);
            exp_ur = 1'b0;
            if (load) begin
                frames++;
                if (pending.size() == 0) begin
                    word = '0;
                    exp_ur = 1'b1;
                    underruns++;
                end else begin
                    word = pending.pop_front();
                end
            end
            check("bclk",        {31'd0, obs_bclk},  32'((n / div_m) % 2));
            check("lrclk",       {31'd0, obs_lrclk}, {31'd0, (k_cur >= 15 && k_cur <= 30)});
            check("sdata",       {31'd0, obs_sdata}, {31'd0, word[31 - k_cur]});
            check("frame_start", {31'd0, obs_fs},    {31'd0, load});
            check("underrun",    {31'd0, obs_ur},    {31'd0, exp_ur});
            check("ready",       {31'd0, obs_ready}, {31'd0, pending.size() == 0});
        end
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        run(cycles);
        reset = 1'b0;
    endtask

    task automatic run_incrementing(input int cycles);
        repeat (cycles) begin
            step();
            if (last_accept) begin
                sample_left  = sample_left + 16'sd1;
                sample_right = sample_right - 16'sd3;
            end
        end
    endtask

    initial begin
        bit found;
        int frames_before;
        sel          = 1'b0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_left  = '0;
        sample_right = '0;

        // Reset, then a constant pair held valid: 8001 left, 7FFE right.
        do_reset(3);
        sample_left  = 16'sh8001;
        sample_right = 16'sh7FFE;
        sample_valid = 1'b1;
        run(2 * 256 + 20);

        // No valid for three frames: zero data, underrun with every frame_start.
        sample_valid = 1'b0;
        do_reset(2);
        underruns = 0;
        run(8 + 2 * 256 + 4);
        check("underrun_count", 32'(underruns), 32'd3);

        // Valid held with an incrementing pair: one pair consumed per frame.
        do_reset(2);
        sample_left  = 16'sh0100;
        sample_right = -16'sh0100;
        sample_valid = 1'b1;
        frames_before = frames;
        run_incrementing(4 * 256 + 16);
        check("frames_consumed", 32'(frames - frames_before), 32'd5);

        // Valid raised only on the second boundary cycle with an empty buffer.
        sample_valid = 1'b0;
        do_reset(2);
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (is_load(n + 1) && (n + 1) > 2 * div_m) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("bypass_boundary_found", {31'd0, found}, 32'd1);
        sample_left  = 16'sh5A3C;
        sample_right = 16'shC3A5;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("bypass_fs", {31'd0, obs_fs}, 32'd1);
        check("bypass_ur", {31'd0, obs_ur}, 32'd0);
        run(260);

        // Random traffic: sparse offers first, then dense offers.
        do_reset(2);
        for (int i = 0; i < 3 * 256 + 16; i++) begin
            sample_valid = ($urandom_range(0, 299) == 0);
            sample_left  = sample_t'($urandom);
            sample_right = sample_t'($urandom);
            step();
        end
        for (int i = 0; i < 3 * 256; i++) begin
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_left  = sample_t'($urandom);
            sample_right = sample_t'($urandom);
            step();
        end

        // Reset in the middle of a frame at bit 20, then restart cleanly.
        sample_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (k_cur == 20 && n > 300) begin
                found = 1'b1;
                break;
            end
            run_incrementing(1);
        end
        check("midreset_bit20_found", {31'd0, found}, 32'd1);
        do_reset(1);
        run_incrementing(600);

        // DIV=2 build: same checks with a 4-cycle BCLK and 128-cycle frame.
        sel   = 1'b1;
        div_m = DIV_B;
        sample_valid = 1'b0;
        do_reset(2);
        sample_valid = 1'b1;
        sample_left  = 16'sh1234;
        sample_right = 16'shFEDC;
        frames_before = frames;
        run_incrementing(3 * 128 + 8);
        check("div2_frames", 32'(frames - frames_before), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
